// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - time-multiplexed array of leaky integrate-and-fire neurons
//
// One shared update datapath walks the neurons one per cycle for each accepted step.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   step_valid      timestep request; accepted when step_ready is high
//   step_ready      high while idle
//   cur_in          packed per-neuron input currents, neuron k at [k*I_WIDTH +: I_WIDTH]
//   threshold       firing threshold
//   leak_shift      leak is V >> leak_shift, 0 disables leak
//   refrac_steps    steps a neuron sits out after firing
//   reset_mode      0: V to 0 after spike, 1: V to V_next - threshold
//   spike_out       spike vector of the last completed step
//   spike_valid     one-cycle pulse when spike_out is updated
//   v_sel, v_out    registered membrane readout of neuron v_sel
module lif_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int V_WIDTH   = 8,
    parameter int I_WIDTH   = 8,
    parameter int R_WIDTH   = 4,
    localparam int SEL_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step_valid,
    output logic                         step_ready,
    input  logic [N_NEURONS*I_WIDTH-1:0] cur_in,
    input  logic [V_WIDTH-1:0]           threshold,
    input  logic [2:0]                   leak_shift,
    input  logic [R_WIDTH-1:0]           refrac_steps,
    input  logic                         reset_mode,
    output logic [N_NEURONS-1:0]         spike_out,
    output logic                         spike_valid,
    input  logic [SEL_W-1:0]             v_sel,
    output logic [V_WIDTH-1:0]           v_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_NEURONS - 1);

    logic [1:0]                   state;
    logic [SEL_W-1:0]             idx;
    logic [N_NEURONS-1:0]         spike_acc;

    logic [N_NEURONS*I_WIDTH-1:0] cur_lat;
    logic [V_WIDTH-1:0]           thr_lat;
    logic [2:0]                   leak_lat;
    logic [R_WIDTH-1:0]           refrac_lat;
    logic                         mode_lat;

    logic [V_WIDTH-1:0]           v_mem [N_NEURONS];
    logic [R_WIDTH-1:0]           r_mem [N_NEURONS];

    logic [V_WIDTH-1:0]           v_cur;
    logic [R_WIDTH-1:0]           r_cur;
    logic [I_WIDTH-1:0]           i_cur;
    logic [V_WIDTH:0]             leak_amt;
    logic [V_WIDTH:0]             sum;
    logic [V_WIDTH-1:0]           v_next;
    logic [V_WIDTH-1:0]           v_after;
    logic [R_WIDTH-1:0]           r_after;
    logic                         refractory;
    logic                         fire;

    assign step_ready = (state == S_IDLE) && !rst;

    // Shared update for neuron idx. The sum is one bit wider than V so that
    // V - leak + I cannot wrap (leak <= V and I_WIDTH <= V_WIDTH).
    always_comb begin
        v_cur      = v_mem[idx];
        r_cur      = r_mem[idx];
        i_cur      = cur_lat[idx*I_WIDTH +: I_WIDTH];
        leak_amt   = (leak_lat != 3'd0) ? ({1'b0, v_cur} >> leak_lat) : '0;
        sum        = {1'b0, v_cur} - leak_amt + (V_WIDTH+1)'(i_cur);
        v_next     = sum[V_WIDTH] ? '1 : sum[V_WIDTH-1:0];
        refractory = (r_cur != '0);
        fire       = !refractory && (v_next >= thr_lat);
        v_after    = v_next;
        r_after    = r_cur;
        if (refractory) begin
            v_after = '0;
            r_after = r_cur - R_WIDTH'(1);
        end else if (fire) begin
            // v_next >= thr_lat here, so the subtraction cannot underflow
            v_after = mode_lat ? (v_next - thr_lat) : '0;
            r_after = refrac_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            spike_acc   <= '0;
            spike_out   <= '0;
            spike_valid <= 1'b0;
            v_out       <= '0;
            cur_lat     <= '0;
            thr_lat     <= '0;
            leak_lat    <= '0;
            refrac_lat  <= '0;
            mode_lat    <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k] <= '0;
                r_mem[k] <= '0;
            end
        end else begin
            spike_valid <= 1'b0;
            // Reads the pre-update value when v_sel matches the neuron written this cycle
            v_out <= (32'(v_sel) < N_NEURONS) ? v_mem[v_sel] : '0;
            case (state)
                S_IDLE: begin
                    if (step_valid) begin
                        cur_lat    <= cur_in;
                        thr_lat    <= threshold;
                        leak_lat   <= leak_shift;
                        refrac_lat <= refrac_steps;
                        mode_lat   <= reset_mode;
                        idx        <= '0;
                        spike_acc  <= '0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    v_mem[idx]     <= v_after;
                    r_mem[idx]     <= r_after;
                    spike_acc[idx] <= fire;
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + SEL_W'(1);
                    end
                end
                S_DONE: begin
                    spike_out   <= spike_acc;
                    spike_valid <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Time-multiplexed array of `N_NEURONS` leaky integrate-and-fire neurons sharing one update datapath. It is the parametrised successor to the single-neuron LIF core. It adds:
- configurable neuron count and widths;
- a refractory period;
- selectable reset mode (zero or subtract-threshold);
- a valid/ready step handshake.

It sits behind the top-level pin wrapper, which packs per-neuron input currents into `cur_in` and reads back `spike_out` and `v_out`.

## Interface
- `N_NEURONS`, 4: neurons in the array, ≥1.
- `V_WIDTH`, 8: membrane potential and threshold width, unsigned.
- `I_WIDTH`, 8: per-neuron input current width, unsigned, ≤ `V_WIDTH`.
- `R_WIDTH`, 4: refractory counter width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `step_valid`  in  1  a timestep request is presented.
- `step_ready`  out  1  array is idle and can accept a step.
- `cur_in`  in  `N_NEURONS*I_WIDTH`  input currents; neuron k uses bits `[k*I_WIDTH +: I_WIDTH]`.
- `threshold`  in  `V_WIDTH`  firing threshold.
- `leak_shift`  in  3  leak amount is V >> `leak_shift`; 0 disables leak.
- `refrac_steps`  in  `R_WIDTH`  number of steps a neuron sits out after firing.
- `reset_mode`  in  1  after a spike: 0 sets V to 0; 1 sets V to V_next − threshold.
- `spike_out`  out  `N_NEURONS`  spike vector of the last completed step.
- `spike_valid`  out  1  one-cycle pulse when `spike_out` is updated.
- `v_sel`  in  `clog2(N_NEURONS)` (min 1)  membrane readout select.
- `v_out`  out  `V_WIDTH`  registered membrane value of neuron `v_sel`.

## Operation
- **State per neuron:** membrane `V[k]` (`V_WIDTH`) and refractory counter `R[k]` (`R_WIDTH`).
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `step_ready` = 1.
  - On `step_valid && step_ready`, latch `cur_in`, `threshold`, `leak_shift`, `refrac_steps` and `reset_mode`.
  - Clear index to 0 and go to RUN.
- **RUN:** processes neuron `idx` each cycle, one neuron per cycle.
  - If `R[idx] != 0`:
    - `R` decrements and `V` is held at 0;
    - no integration; spike bit = 0.
  - Otherwise, in `V_WIDTH+1` bits: `V_next = V − (leak_shift ? V >> leak_shift : 0) + I`, saturated to 2^`V_WIDTH` − 1.
  - If `V_next >= threshold`:
    - spike bit = 1 and `R` loads `refrac_steps`;
    - `V` becomes 0 (mode 0) or `V_next − threshold` (mode 1).
  - Otherwise `V` = `V_next` and spike bit = 0.
  - `threshold` = 0 means every non-refractory neuron fires every step.
  - After `idx == N_NEURONS−1`, go to DONE.
- **DONE:**
  - Transfer the accumulated spike bits to `spike_out` and assert `spike_valid` for this cycle.
  - Return to IDLE.
- `step_valid` outside IDLE is ignored; nothing is queued.
- `cur_in` and the config inputs may change freely after acceptance; only the latched copies are used.
- **`rst`:**
  - all `V`, `R` = 0; `spike_out` = 0; `spike_valid` = 0; `v_out` = 0; FSM to IDLE.
  - Reset during RUN or DONE aborts the step: no `spike_valid` and no partial update survives.

## Timing
- **Reset values:**
  - `step_ready` = 0 while `rst` is high, and 1 on the first cycle after `rst` is released.
  - `spike_out` = 0, `spike_valid` = 0, `v_out` = 0.
- **Latency:**
  - Accept at edge T.
  - RUN covers edges T+1 … T+`N_NEURONS`.
  - `spike_valid` is high during the cycle after edge T+`N_NEURONS`+1.
  - The next accept is possible at edge T+`N_NEURONS`+2.
- **Throughput:** one step per `N_NEURONS`+2 cycles.
- `step_ready` is combinational from the state (IDLE only).
- `v_out` updates every cycle from `V[v_sel]`, with 1-cycle latency.
  - While `v_sel` points at the neuron being written this cycle, `v_out` shows the old value.
- `spike_out` holds its value between `spike_valid` pulses.

## Test plan
All scenarios use N=4, V_WIDTH=8, I_WIDTH=8.
- **Reset:** hold `rst` for 3 cycles → all outputs 0; `step_ready`=1 on the first cycle after release; `v_out`=0 for every `v_sel`.
- **Integrate/fire, mode 0:** threshold=100, leak_shift=0, refrac=0, neuron0 cur=30, others 0.
  - V0 = 30, 60, 90 across steps 1–3.
  - Step 4: `spike_out`=4'b0001 and V0=0.
  - Same with mode 1 → V0=20 after step 4.
- **Leak:** threshold=200, leak_shift=1, one step with cur=64, then steps with cur=0 → V0 = 64, 32, 16, 8, no spikes.
- **Saturation:** threshold=255, leak=0, cur=200 on two steps → V0=200, then saturates at 255 → spike, V0=0 (mode 0).
- **Refractory:** threshold=50, refrac=2, cur=60 every step → spikes on steps 1, 4, 7; V0=0 and no spike on steps 2, 3, 5, 6.
- **Handshake and abort:**
  - `step_valid` held high continuously → `spike_valid` pulses exactly every 6 cycles.
  - Assert `rst` at the 2nd RUN cycle → no `spike_valid`; all V=0 afterwards.
